// File: rtl/watch_set_controller.sv
// Mode/time-set sequencer for the watch counter chain.
// Synchronizes and edge-detects three debounced buttons, freezes the chain and
// captures its time, lets the user edit hours, minutes and seconds, then
// commits the edited time with a one-cycle load strobe and restarts the chain.
// An idle SET session aborts to the frozen time after SET_TIMEOUT cycles.
module watch_set_controller #(
  parameter int unsigned HR_MAX      = 23,
  parameter logic [31:0] SET_TIMEOUT = 32'd5000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mode_btn,
  input  logic       adj_btn,
  input  logic       run_btn,
  input  logic [3:0] cur_hr1,
  input  logic [3:0] cur_hr0,
  input  logic [3:0] cur_min1,
  input  logic [3:0] cur_min0,
  input  logic [3:0] cur_sec1,
  input  logic [3:0] cur_sec0,
  output logic       stop,
  output logic       start_resume,
  output logic       load,
  output logic [3:0] ld_hr1,
  output logic [3:0] ld_hr0,
  output logic [3:0] ld_min1,
  output logic [3:0] ld_min0,
  output logic [3:0] ld_sec1,
  output logic [3:0] ld_sec0,
  output logic [2:0] state_o,
  output logic       timeout_o
);

  typedef enum logic [2:0] {
    ST_RUN     = 3'd0,
    ST_SET_HR  = 3'd1,
    ST_SET_MIN = 3'd2,
    ST_SET_SEC = 3'd3,
    ST_COMMIT  = 3'd4,
    ST_RESUME  = 3'd5
  } state_e;

  typedef struct packed {
    logic [3:0] hr1;
    logic [3:0] hr0;
    logic [3:0] min1;
    logic [3:0] min0;
    logic [3:0] sec1;
    logic [3:0] sec0;
  } bcd_time_t;

  // Button bit order in the synchronizer vectors.
  localparam int unsigned B_MODE = 0;
  localparam int unsigned B_ADJ  = 1;
  localparam int unsigned B_RUN  = 2;

  // BCD hour increment; anything at or above HR_MAX wraps to 00 so a
  // captured out-of-range hour still lands back in the legal range.
  function automatic logic [7:0] hr_inc(input logic [3:0] h1, input logic [3:0] h0);
    int unsigned v;
    v = (32'(h1) * 32'd10) + 32'(h0);
    if (v >= HR_MAX)    return 8'h00;
    else if (h0 >= 4'd9) return {h1 + 4'd1, 4'd0};
    else                 return {h1, h0 + 4'd1};
  endfunction

  // BCD minute increment, 59 -> 00, no carry into the hour.
  function automatic logic [7:0] min_inc(input logic [3:0] m1, input logic [3:0] m0);
    if (m0 >= 4'd9) begin
      if (m1 >= 4'd5) return 8'h00;
      else            return {m1 + 4'd1, 4'd0};
    end else begin
      return {m1, m0 + 4'd1};
    end
  endfunction

  // ---------------------------------------------------------------------------
  // Button synchronizer and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [2:0] btn_raw;
  logic [2:0] s1_q, s2_q, prev_q;
  logic [2:0] edge_d, edge_q;

  assign btn_raw = {run_btn, adj_btn, mode_btn};

  // Rising edge of the synchronized level; a held button yields one edge.
  always_comb begin
    edge_d = s2_q & ~prev_q;
  end

  // Two-flop synchronizer, previous-value flop and registered edge pulse.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values and the shift chain does not collapse.
    if (!reset) begin
      s1_q   <= '0;
      s2_q   <= '0;
      prev_q <= '0;
      edge_q <= '0;
    end else begin
      s1_q   <= btn_raw;
      s2_q   <= s1_q;
      prev_q <= s2_q;
      edge_q <= edge_d;
    end
  end

  logic mode_edge, adj_edge, run_edge, any_edge;
  assign mode_edge = edge_q[B_MODE];
  assign adj_edge  = edge_q[B_ADJ];
  assign run_edge  = edge_q[B_RUN];
  assign any_edge  = |edge_q;

  // ---------------------------------------------------------------------------
  // FSM, edit datapath and timeout counter
  // ---------------------------------------------------------------------------
  state_e    state_q, state_d;
  bcd_time_t ld_q, ld_d, cur_time;
  logic [31:0] cnt_q, cnt_d;
  logic stop_q, stop_d;
  logic load_q, load_d;
  logic sr_q, sr_d;
  logic to_q, to_d;

  logic in_set, timeout_hit;
  logic cap_en, inc_hr, inc_min, clr_sec, timed_out;

  assign cur_time = '{hr1: cur_hr1, hr0: cur_hr0, min1: cur_min1,
                      min0: cur_min0, sec1: cur_sec1, sec0: cur_sec0};

  assign in_set      = (state_q == ST_SET_HR) || (state_q == ST_SET_MIN) ||
                       (state_q == ST_SET_SEC);
  assign timeout_hit = (SET_TIMEOUT != 32'd0) && (cnt_q == SET_TIMEOUT - 32'd1);

  // State register together with the registered pulse outputs and edit value.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= ST_RUN;
      ld_q    <= '0;
      cnt_q   <= '0;
      stop_q  <= 1'b0;
      load_q  <= 1'b0;
      sr_q    <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_q    <= ld_d;
      cnt_q   <= cnt_d;
      stop_q  <= stop_d;
      load_q  <= load_d;
      sr_q    <= sr_d;
      to_q    <= to_d;
    end
  end

  // Next-state decode; run beats mode beats adj when edges coincide, and a
  // button edge takes precedence over an expiring timeout.
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // leaves it unassigned and no latch is inferred.
    state_d   = state_q;
    cap_en    = 1'b0;
    inc_hr    = 1'b0;
    inc_min   = 1'b0;
    clr_sec   = 1'b0;
    timed_out = 1'b0;
    case (state_q)
      ST_RUN: begin
        if (mode_edge) begin
          state_d = ST_SET_HR;
          cap_en  = 1'b1;
        end
      end
      ST_SET_HR, ST_SET_MIN, ST_SET_SEC: begin
        if (run_edge) begin
          state_d = ST_COMMIT;
        end else if (mode_edge) begin
          case (state_q)
            ST_SET_HR:  state_d = ST_SET_MIN;
            ST_SET_MIN: state_d = ST_SET_SEC;
            default:    state_d = ST_COMMIT;
          endcase
        end else if (adj_edge) begin
          inc_hr  = (state_q == ST_SET_HR);
          inc_min = (state_q == ST_SET_MIN);
          clr_sec = (state_q == ST_SET_SEC);
        end else if (timeout_hit) begin
          state_d   = ST_RESUME;
          timed_out = 1'b1;
        end
      end
      ST_COMMIT: state_d = ST_RESUME;
      ST_RESUME: state_d = ST_RUN;
      default:   state_d = ST_RUN;
    endcase
  end

  // Edit datapath: capture, per-field increments and seconds clear.
  always_comb begin
    ld_d = ld_q;
    if (cap_en) ld_d = cur_time;
    if (inc_hr) {ld_d.hr1, ld_d.hr0} = hr_inc(ld_q.hr1, ld_q.hr0);
    if (inc_min) {ld_d.min1, ld_d.min0} = min_inc(ld_q.min1, ld_q.min0);
    if (clr_sec) begin
      ld_d.sec1 = 4'd0;
      ld_d.sec0 = 4'd0;
    end
  end

  // Idle counter: runs in SET states, cleared by any button edge and outside SET.
  always_comb begin
    if (in_set && !any_edge) cnt_d = cnt_q + 32'd1;
    else                     cnt_d = '0;
  end

  // Output decode from the upcoming state, registered one level up.
  always_comb begin
    stop_d = (state_q == ST_RUN) && (state_d == ST_SET_HR);
    load_d = (state_d == ST_COMMIT);
    sr_d   = (state_d == ST_RESUME);
    to_d   = timed_out;
  end

  assign stop         = stop_q;
  assign start_resume = sr_q;
  assign load         = load_q;
  assign timeout_o    = to_q;
  assign state_o      = state_q;
  assign ld_hr1       = ld_q.hr1;
  assign ld_hr0       = ld_q.hr0;
  assign ld_min1      = ld_q.min1;
  assign ld_min0      = ld_q.min0;
  assign ld_sec1      = ld_q.sec1;
  assign ld_sec0      = ld_q.sec0;

endmodule

// File: tb/tb_watch_set_controller.sv
// Directed bench for watch_set_controller with HR_MAX=23, SET_TIMEOUT=16.
module tb_watch_set_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mode_btn = 1'b0, adj_btn = 1'b0, run_btn = 1'b0;
  logic [23:0] cur_all = '0;
  logic        stop, start_resume, load, timeout_o;
  logic [3:0]  ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0;
  logic [2:0]  state_o;
  logic [23:0] ld_all;

  always #5 clk = ~clk;

  watch_set_controller #(.HR_MAX(23), .SET_TIMEOUT(32'd16)) dut (
    .clk(clk), .reset(reset),
    .mode_btn(mode_btn), .adj_btn(adj_btn), .run_btn(run_btn),
    .cur_hr1(cur_all[23:20]), .cur_hr0(cur_all[19:16]),
    .cur_min1(cur_all[15:12]), .cur_min0(cur_all[11:8]),
    .cur_sec1(cur_all[7:4]), .cur_sec0(cur_all[3:0]),
    .stop(stop), .start_resume(start_resume), .load(load),
    .ld_hr1(ld_hr1), .ld_hr0(ld_hr0), .ld_min1(ld_min1),
    .ld_min0(ld_min0), .ld_sec1(ld_sec1), .ld_sec0(ld_sec0),
    .state_o(state_o), .timeout_o(timeout_o)
  );

  assign ld_all = {ld_hr1, ld_hr0, ld_min1, ld_min0, ld_sec1, ld_sec0};

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Pulse monitor, sampled 1 time unit after each rising edge.
  int cyc = 0, n_stop = 0, n_load = 0, n_sr = 0, n_to = 0, n_overlap = 0;
  int stop_cyc = 0, load_cyc = 0, sr_cyc = 0, to_cyc = 0;
  logic [23:0] load_val = '0;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (stop === 1'b1) begin n_stop++; stop_cyc = cyc; end
    if (load === 1'b1) begin n_load++; load_cyc = cyc; load_val = ld_all; end
    if (start_resume === 1'b1) begin n_sr++; sr_cyc = cyc; end
    if (timeout_o === 1'b1) begin n_to++; to_cyc = cyc; end
    if (load === 1'b1 && start_resume === 1'b1) n_overlap++;
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Press pattern: the action lands on the 4th rising edge after driving high.
  task automatic press(input logic m, input logic a, input logic r);
    mode_btn = m; adj_btn = a; run_btn = r;
    tick(4);
    mode_btn = 1'b0; adj_btn = 1'b0; run_btn = 1'b0;
    tick(3);
  endtask

  int s_stop, s_load, s_sr, s_to;
  task automatic snap();
    s_stop = n_stop; s_load = n_load; s_sr = n_sr; s_to = n_to;
  endtask

  initial begin
    // Reset with a button press that must be forgotten.
    @(negedge clk);
    mode_btn = 1'b1;
    tick(2);
    check("rst_state", 32'(state_o), 32'd0);
    check("rst_pulses", {28'd0, stop, start_resume, load, timeout_o}, 32'd0);
    check("rst_ld", 32'(ld_all), 32'h0);
    mode_btn = 1'b0;
    tick(1);
    reset = 1'b1;
    tick(8);
    check("rst_release_state", 32'(state_o), 32'd0);
    check("rst_release_stop", 32'(n_stop), 32'd0);

    // Capture 12:34:56 and walk through all fields.
    cur_all = 24'h123456;
    snap();
    press(1, 0, 0);
    check("cap_stop", 32'(n_stop - s_stop), 32'd1);
    check("cap_state", 32'(state_o), 32'd1);
    check("cap_ld", 32'(ld_all), 32'h123456);
    check("cap_stop_low", 32'(stop), 32'd0);
    press(1, 0, 0);
    check("walk_min", 32'(state_o), 32'd2);
    press(1, 0, 0);
    check("walk_sec", 32'(state_o), 32'd3);
    snap();
    press(1, 0, 0);
    check("commit_load_cnt", 32'(n_load - s_load), 32'd1);
    check("commit_load_val", 32'(load_val), 32'h123456);
    check("commit_sr_cnt", 32'(n_sr - s_sr), 32'd1);
    check("commit_sr_after", 32'(sr_cyc - load_cyc), 32'd1);
    check("commit_state", 32'(state_o), 32'd0);

    // RUN ignores adj/run and holds ld.
    cur_all = 24'h010101;
    snap();
    press(0, 1, 0);
    press(0, 0, 1);
    check("run_ignore_state", 32'(state_o), 32'd0);
    check("run_hold_ld", 32'(ld_all), 32'h123456);
    check("run_ignore_pulses", 32'((n_stop - s_stop) + (n_load - s_load)), 32'd0);

    // Hour wrap at HR_MAX, then run commits captured min/sec.
    cur_all = 24'h234517;
    press(1, 0, 0);
    press(0, 1, 0);
    check("hr_wrap", 32'(ld_all), 32'h004517);
    snap();
    press(0, 0, 1);
    check("run_commit_cnt", 32'(n_load - s_load), 32'd1);
    check("run_commit_val", 32'(load_val), 32'h004517);

    // BCD carries and seconds clear.
    cur_all = 24'h095930;
    press(1, 0, 0);
    press(0, 1, 0);
    check("hr_carry", 32'(ld_all), 32'h105930);
    press(1, 0, 0);
    press(0, 1, 0);
    check("min_wrap", 32'(ld_all), 32'h100030);
    press(1, 0, 0);
    press(0, 1, 0);
    check("sec_clear", 32'(ld_all), 32'h100000);
    press(1, 0, 0);
    check("edit_commit_val", 32'(load_val), 32'h100000);
    check("no_overlap", 32'(n_overlap), 32'd0);

    // Same-cycle mode+adj in SET_MIN: mode wins, adj dropped.
    cur_all = 24'h082711;
    press(1, 0, 0);
    press(1, 0, 0);
    press(1, 1, 0);
    check("prio_state", 32'(state_o), 32'd3);
    check("prio_ld", 32'(ld_all), 32'h082711);
    press(0, 0, 1);
    check("prio_commit", 32'(load_val), 32'h082711);

    // Timeout with no buttons after entry.
    cur_all = 24'h010203;
    snap();
    press(1, 0, 0);
    for (int i = 0; i < 40 && n_to == s_to; i++) tick(1);
    tick(3);
    check("to_pulse", 32'(n_to - s_to), 32'd1);
    check("to_delay", 32'(to_cyc - stop_cyc), 32'd16);
    check("to_sr", 32'(sr_cyc), 32'(to_cyc));
    check("to_sr_cnt", 32'(n_sr - s_sr), 32'd1);
    check("to_no_load", 32'(n_load - s_load), 32'd0);
    check("to_state", 32'(state_o), 32'd0);
    check("to_ld_hold", 32'(ld_all), 32'h010203);

    // Reset in the middle of an edit session.
    cur_all = 24'h111111;
    press(1, 0, 0);
    press(1, 0, 0);
    press(0, 1, 0);
    check("mid_edit", 32'(ld_all), 32'h111211);
    snap();
    reset = 1'b0;
    tick(1);
    check("mid_rst_state", 32'(state_o), 32'd0);
    check("mid_rst_ld", 32'(ld_all), 32'h0);
    tick(1);
    reset = 1'b1;
    tick(5);
    check("mid_rst_no_load", 32'((n_load - s_load) + (n_sr - s_sr)), 32'd0);
    check("mid_rst_idle", 32'(state_o), 32'd0);

    // Held adj for 10 cycles gives exactly one increment.
    cur_all = 24'h051020;
    press(1, 0, 0);
    adj_btn = 1'b1;
    tick(10);
    adj_btn = 1'b0;
    tick(3);
    check("held_adj", 32'(ld_all), 32'h061020);
    press(0, 0, 1);
    check("held_commit", 32'(load_val), 32'h061020);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
